// File: rtl/monitor_nivel_agua.sv
// Water-level monitor for N active-low tank sensors.
// Synchronises and debounces the raw sensor vector, encodes the highest wet sensor,
// flags empty and non-monotonic readings, and drives a single 7-segment digit.
// Optional build macro NIVEL_FALHA_TRAVA_EN: when defined, the fault flag latches until reset.
module monitor_nivel_agua #(
  parameter int unsigned N_SENSORES      = 5,
  parameter int unsigned DEBOUNCE_CICLOS = 1000,
  parameter bit          CATODO_COMUM    = 1'b1,
  localparam int unsigned NIVEL_W = ($clog2(N_SENSORES) < 1) ? 1 : $clog2(N_SENSORES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_SENSORES-1:0] sensores_in,
  output logic [NIVEL_W-1:0]    nivel,
  output logic                  vazio,
  output logic                  falha,
  output logic                  mudou,
  output logic [6:0]            display_out
);

  localparam int unsigned       CONT_W   = $clog2(DEBOUNCE_CICLOS) + 1;
  localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);
  localparam logic [6:0]        SEG_E    = 7'b1111001;
  localparam logic [6:0]        SEG_0    = 7'b0111111;
  localparam logic [6:0]        DISP_RST = CATODO_COMUM ? SEG_0 : ~SEG_0;

  // Common-cathode segment codes {g,f,e,d,c,b,a} for decimal digits.
  function automatic logic [6:0] seg_digito(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [N_SENSORES-1:0] sync1_q, sync2_q;
  logic [N_SENSORES-1:0] cand_q, filt_q;
  logic [CONT_W-1:0]     cont_q;

  logic [NIVEL_W-1:0] nivel_q, nivel_d;
  logic               vazio_q, vazio_d;
  logic               falha_q, falha_d;
  logic               mudou_q, mudou_d;
  logic [6:0]         disp_q, disp_d;

  // Two-flop synchroniser; idles at "all dry" so reset never looks like water.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sensores_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: any change restarts the count; the counter saturates and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= '1;
      cont_q <= '0;
      filt_q <= '1;
    end else if (sync2_q != cand_q) begin
      cand_q <= sync2_q;
      cont_q <= '0;
    end else if (cont_q < CONT_MAX) begin
      cont_q <= cont_q + 1'b1;
    end else if (filt_q != cand_q) begin
      filt_q <= cand_q;
    end
  end

  // Decode the committed vector into next output values.
  always_comb begin
    logic seco_abaixo;
    logic falha_bruta;
    logic mudanca;
    logic [6:0] seg_cc;
    nivel_d     = '0;
    vazio_d     = &filt_q;
    seco_abaixo = 1'b0;
    falha_bruta = 1'b0;
    // Ascending scan: the last wet bit seen is the highest one.
    for (int k = 0; k < int'(N_SENSORES); k++) begin
      if (!filt_q[k]) begin
        nivel_d = NIVEL_W'(k);
        if (seco_abaixo) falha_bruta = 1'b1;
      end else begin
        seco_abaixo = 1'b1;
      end
    end
`ifdef NIVEL_FALHA_TRAVA_EN
    falha_d = falha_q | falha_bruta;
`else
    falha_d = falha_bruta;
`endif
    mudanca = (nivel_d != nivel_q) || (vazio_d != vazio_q) || (falha_d != falha_q);
`ifdef NIVEL_FALHA_TRAVA_EN
    // Once latched, the display is frozen on "E", so level changes are not announced.
    mudou_d = falha_q ? 1'b0 : mudanca;
`else
    mudou_d = mudanca;
`endif
    seg_cc = falha_d ? SEG_E : seg_digito(4'(nivel_d));
    disp_d = CATODO_COMUM ? seg_cc : ~seg_cc;
  end

  // Output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nivel_q <= '0;
      vazio_q <= 1'b1;
      falha_q <= 1'b0;
      mudou_q <= 1'b0;
      disp_q  <= DISP_RST;
    end else begin
      nivel_q <= nivel_d;
      vazio_q <= vazio_d;
      falha_q <= falha_d;
      mudou_q <= mudou_d;
      disp_q  <= disp_d;
    end
  end

  assign nivel       = nivel_q;
  assign vazio       = vazio_q;
  assign falha       = falha_q;
  assign mudou       = mudou_q;
  assign display_out = disp_q;

endmodule
